inst_issuer: RTL and testbench

- Sequencing front-end that drives the CPU's 16-bit `inst` input and samples its 16-bit `result` output.
- Buffers instructions written by a host in an internal FIFO.
- On `start`, presents each instruction to the CPU for a fixed, opcode-dependent number of clock cycles, then captures the CPU result and returns it to the host with a valid pulse.
- Replaces hand-timed instruction driving with a synthesizable issuer.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/inst_fifo.sv | 65 ++++++
 rtl/inst_issuer.sv | 107 ++++++++++
 tb/tb_inst_issuer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/data widths, opcode constants and the
// issuer FSM state encoding.
package cpu_pkg;

    localparam int INST_W = 16;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_SUM  = 4'b0000;
    localparam logic [3:0] OP_ANDI = 4'b0001;
    localparam logic [3:0] OP_ORI  = 4'b0010;
    localparam logic [3:0] OP_XORI = 4'b0011;
    localparam logic [3:0] OP_SUMI = 4'b0101;
    localparam logic [3:0] OP_SUBI = 4'b1001;
    localparam logic [3:0] OP_CMPI = 4'b1011;
    localparam logic [3:0] OP_MOVI = 4'b1101;
    localparam logic [3:0] OP_LOAD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        CAPTURE = 2'd3
    } issue_state_t;

    function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[15:12];
    endfunction

    function automatic logic is_load(input logic [INST_W-1:0] inst);
        return opcode_of(inst) == OP_LOAD;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Circular instruction buffer with occupancy count and a sticky overflow flag.
// A write while full is dropped, even if an entry is popped in the same cycle.
module inst_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_issuer.sv
// Instruction issuer: buffers host instructions and presents each one to the
// CPU for an opcode-dependent number of cycles, then returns the CPU result.
module inst_issuer
    import cpu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LOAD_HOLD = 3,
    parameter int ALU_HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [INST_W-1:0]        wr_inst,
    input  logic                     start,
    output logic [INST_W-1:0]        inst_out,
    output logic                     inst_valid,
    input  logic [DATA_W-1:0]        cpu_result,
    output logic                     res_valid,
    output logic [DATA_W-1:0]        res_data,
    output logic [$clog2(DEPTH)-1:0] res_idx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int MAX_HOLD = (LOAD_HOLD > ALU_HOLD) ? LOAD_HOLD : ALU_HOLD;
    localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    issue_state_t      state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  issue_idx;
    logic [INST_W-1:0] head;
    logic [IDX_W:0]    count;
    logic              has_entry;
    logic              pop;

    assign has_entry = (count != '0);
    assign pop       = (state == FETCH);
    assign busy      = (state != IDLE);

    inst_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(INST_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_data(wr_inst),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .count    (count)
    );

    // The hold counter holds the remaining HOLD cycles minus one, so a value
    // of zero in HOLD means this is the final cycle before capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_idx    <= '0;
            hold_cnt   <= '0;
            issue_idx  <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && has_entry) begin
                        issue_idx <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    inst_out   <= head;
                    inst_valid <= 1'b1;
                    hold_cnt   <= is_load(head) ? HOLD_W'(LOAD_HOLD - 1)
                                                : HOLD_W'(ALU_HOLD - 1);
                    state      <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                CAPTURE: begin
                    res_data   <= cpu_result;
                    res_idx    <= issue_idx;
                    res_valid  <= 1'b1;
                    issue_idx  <= issue_idx + IDX_W'(1);
                    inst_valid <= 1'b0;
                    state      <= has_entry ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_issuer.sv
// Self-checking bench for inst_issuer: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_inst_issuer;
    import cpu_pkg::*;

    localparam int DEPTH     = 8;
    localparam int LOAD_HOLD = 3;
    localparam int ALU_HOLD  = 2;
    localparam int IDX_W     = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [15:0]      wr_inst = '0;
    logic             start = 1'b0;
    logic [15:0]      cpu_result = '0;
    logic [15:0]      inst_out;
    logic             inst_valid;
    logic             res_valid;
    logic [15:0]      res_data;
    logic [IDX_W-1:0] res_idx;
    logic             busy;
    logic             full;
    logic             empty;
    logic             overflow;

    always #5 clk = ~clk;

    inst_issuer #(
        .DEPTH(DEPTH),
        .LOAD_HOLD(LOAD_HOLD),
        .ALU_HOLD(ALU_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_inst   (wr_inst),
        .start     (start),
        .inst_out  (inst_out),
        .inst_valid(inst_valid),
        .cpu_result(cpu_result),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .busy      (busy),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    int pass_count  = 0;
    int check_count = 0;
    int cyc         = 0;
    bit checking    = 0;
    bit echo        = 0;
    bit rand_res    = 0;

    // Behavioural model: a queue of pending instructions and a position within
    // the current instruction's window of (hold + 2) cycles.
    logic [15:0]      mq[$];
    bit               m_run = 0;
    int               m_t = 0;
    int               m_len = 0;
    int               m_idx = 0;
    bit               m_ov = 0;
    logic [15:0]      m_cur = '0;
    logic [15:0]      m_inst_out = '0;
    bit               m_res_valid = 0;
    logic [15:0]      m_res_data = '0;
    logic [IDX_W-1:0] m_res_idx = '0;

    int          res_cyc_q[$];
    logic [15:0] res_data_q[$];
    int          res_idx_q[$];
    int          valid_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        int n;
        bit push_ok;
        cyc++;
        n = mq.size();
        if (rst) begin
            mq.delete();
            m_run       = 0;
            m_t         = 0;
            m_idx       = 0;
            m_ov        = 0;
            m_inst_out  = '0;
            m_res_valid = 0;
            m_res_data  = '0;
            m_res_idx   = '0;
            checking    = 1;
        end else begin
            push_ok = wr_en && (n < DEPTH);
            if (wr_en && n == DEPTH) m_ov = 1;
            m_res_valid = 0;
            if (!m_run) begin
                if (start && n > 0) begin
                    m_run = 1;
                    m_t   = 0;
                    m_idx = 0;
                end
            end else if (m_t == 0) begin
                m_cur      = mq.pop_front();
                m_inst_out = m_cur;
                m_len      = ((m_cur[15:12] == 4'hF) ? LOAD_HOLD : ALU_HOLD) + 2;
                m_t        = 1;
            end else if (m_t == m_len - 1) begin
                m_res_valid = 1;
                m_res_data  = cpu_result;
                m_res_idx   = IDX_W'(m_idx);
                m_idx       = (m_idx + 1) % DEPTH;
                if (n > 0) m_t = 0;
                else m_run = 0;
            end else begin
                m_t++;
            end
            if (push_ok) mq.push_back(wr_inst);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("inst_out",   inst_out,   m_inst_out);
            checkOutput("inst_valid", inst_valid, (m_run && m_t != 0));
            checkOutput("res_valid",  res_valid,  m_res_valid);
            checkOutput("res_data",   res_data,   m_res_data);
            checkOutput("res_idx",    res_idx,    m_res_idx);
            checkOutput("busy",       busy,       m_run);
            checkOutput("full",       full,       (mq.size() == DEPTH));
            checkOutput("empty",      empty,      (mq.size() == 0));
            checkOutput("overflow",   overflow,   m_ov);
        end
        if (res_valid) begin
            res_cyc_q.push_back(cyc);
            res_data_q.push_back(res_data);
            res_idx_q.push_back(int'(res_idx));
        end
        if (inst_valid) valid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (echo) cpu_result = inst_out ^ 16'hA5A5;
        else if (rand_res) cpu_result = 16'($urandom);
    endtask

    task automatic applyStimulus(input logic w, input logic [15:0] d,
                                 input logic s, input logic r);
        wr_en   = w;
        wr_inst = d;
        start   = s;
        rst     = r;
        tick();
        wr_en   = 1'b0;
        start   = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        res_cyc_q.delete();
        res_data_q.delete();
        res_idx_q.delete();
        valid_cnt = 0;
    endtask

    initial begin : stimulus
        int c0;
        logic [15:0] vals[9];
        int seq_off[3];
        seq_off[0] = 5;
        seq_off[1] = 10;
        seq_off[2] = 14;

        // Reset, then start with an empty FIFO
        applyStimulus(0, 16'h0, 0, 1);
        applyStimulus(0, 16'h0, 0, 1);
        checkOutput("reset_inst_out", inst_out, 16'h0000);
        checkOutput("reset_empty", empty, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        applyStimulus(0, 16'h0, 1, 0);
        idle(2);
        checkOutput("empty_start_busy", busy, 1'b0);

        // Single load
        cpu_result = 16'h1234;
        applyStimulus(1, 16'hF10F, 0, 0);
        clear_log();
        applyStimulus(0, 16'h0, 1, 0);
        c0 = cyc;
        idle(10);
        checkOutput("load_pulses", res_cyc_q.size(), 1);
        checkOutput("load_valid_cycles", valid_cnt, 4);
        if (res_cyc_q.size() >= 1) begin
            checkOutput("load_latency", res_cyc_q[0] - c0, 5);
            checkOutput("load_data", res_data_q[0], 16'h1234);
            checkOutput("load_idx", res_idx_q[0], 0);
        end

        // Load, load, ALU sequence
        applyStimulus(1, 16'hF10F, 0, 0);
        applyStimulus(1, 16'hF10F, 0, 0);
        applyStimulus(1, 16'h0051, 0, 0);
        clear_log();
        applyStimulus(0, 16'h0, 1, 0);
        c0 = cyc;
        idle(20);
        checkOutput("seq_pulses", res_cyc_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (res_cyc_q.size() > k) begin
                checkOutput("seq_time", res_cyc_q[k] - c0, seq_off[k]);
                checkOutput("seq_idx", res_idx_q[k], k);
            end
        end
        checkOutput("seq_end_empty", empty, 1'b1);
        checkOutput("seq_end_busy", busy, 1'b0);

        // Overflow: nine writes into eight entries, results echo the instruction
        for (int i = 0; i < 9; i++) begin
            vals[i] = (i % 3 == 0) ? (16'hF000 | 16'(i)) : (16'h3100 | 16'(i));
            applyStimulus(1, vals[i], 0, 0);
            if (i == 7) checkOutput("full_after_8", full, 1'b1);
        end
        checkOutput("overflow_after_9", overflow, 1'b1);
        echo = 1;
        clear_log();
        applyStimulus(0, 16'h0, 1, 0);
        idle(50);
        echo = 0;
        checkOutput("ovf_result_count", res_data_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (res_data_q.size() > i) begin
                checkOutput("ovf_order", res_data_q[i], vals[i] ^ 16'hA5A5);
            end
        end
        applyStimulus(0, 16'h0, 0, 1);
        checkOutput("overflow_cleared", overflow, 1'b0);

        // Write during HOLD continues without an idle cycle
        cpu_result = 16'h0BEE;
        applyStimulus(1, 16'h0051, 0, 0);
        clear_log();
        applyStimulus(0, 16'h0, 1, 0);
        c0 = cyc;
        idle(1);
        applyStimulus(1, 16'h5051, 0, 0);
        idle(12);
        checkOutput("run_write_pulses", res_cyc_q.size(), 2);
        if (res_cyc_q.size() >= 2) begin
            checkOutput("run_write_first", res_cyc_q[0] - c0, 4);
            checkOutput("run_write_second", res_cyc_q[1] - c0, 8);
            checkOutput("run_write_idx", res_idx_q[1], 1);
        end

        // Reset during the second HOLD cycle aborts the instruction
        applyStimulus(1, 16'hF10F, 0, 0);
        clear_log();
        applyStimulus(0, 16'h0, 1, 0);
        idle(2);
        applyStimulus(0, 16'h0, 0, 1);
        checkOutput("abort_inst_valid", inst_valid, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_empty", empty, 1'b1);
        checkOutput("abort_res_valid", res_valid, 1'b0);
        idle(8);
        checkOutput("abort_no_result", res_cyc_q.size(), 0);

        // Randomized traffic against the model
        rand_res = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 2) == 0) ? OP_LOAD : 4'($urandom);
            applyStimulus($urandom_range(0, 99) < 35,
                          {op, 12'($urandom)},
                          $urandom_range(0, 99) < 8,
                          $urandom_range(0, 999) < 3);
        end
        idle(60);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
